// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game video path: palette, background
// state encoding, screen indices and the button-to-colour priority map.
package simon_pkg;

  localparam logic [11:0] COL_RED    = 12'hF00;
  localparam logic [11:0] COL_BLUE   = 12'h01F;
  localparam logic [11:0] COL_YELLOW = 12'hFF0;
  localparam logic [11:0] COL_GREEN  = 12'h0F0;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;
  localparam logic [11:0] COL_BLACK  = 12'h000;

  typedef enum logic [1:0] {
    WHITE = 2'd0,
    IDLE  = 2'd1,
    PRESS = 2'd2,
    HOLD  = 2'd3
  } bg_state_t;

  localparam int SCR_BOARD  = 0;
  localparam int SCR_RED    = 1;
  localparam int SCR_BLUE   = 2;
  localparam int SCR_YELLOW = 3;
  localparam int SCR_GREEN  = 4;
  localparam int SCR_LOSE   = 5;
  localparam int SCR_START  = 7;

  // Buttons are {up,right,down,left}; up has highest priority.
  function automatic logic [11:0] btn_colour(input logic [3:0] b);
    logic [11:0] c;
    c = COL_BLACK;
    if (b[3])      c = COL_RED;
    else if (b[2]) c = COL_BLUE;
    else if (b[1]) c = COL_YELLOW;
    else if (b[0]) c = COL_GREEN;
    return c;
  endfunction

endpackage

// File: rtl/simon_delay_line.sv
// Fixed-depth shift register used to align per-pixel flags with the
// image-ROM read latency. Cleared on reset so no stale pixel survives.
module simon_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  // Shift the flags one stage per clock; stage 0 takes the new sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/simon_screen_compositor.sv
// Simon VGA pixel compositor: picks one image-ROM stream inside a fixed
// window, a button-driven background elsewhere, and blanks outside active
// video. Screen selection is latched only at frame start so frames never
// tear; the background lingers for a number of frames after release.
module simon_screen_compositor
  import simon_pkg::*;
#(
  parameter int                     NUM_SCREENS = 8,
  parameter int                     SEL_W       = 3,
  parameter logic [NUM_SCREENS-1:0] SCREEN_EN   = 8'b1011_1111,
  parameter int                     ROM_LATENCY = 1,
  parameter int                     WIN_X0      = 250,
  parameter int                     WIN_Y0      = 125,
  parameter int                     WIN_W       = 381,
  parameter int                     WIN_H       = 251,
  parameter int                     HOLD_FRAMES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic                      bright,
  input  logic [SEL_W-1:0]          screen_sel,
  input  logic [12*NUM_SCREENS-1:0] screen_data,
  input  logic [3:0]                btn,
  output logic [11:0]               rgb,
  output logic [11:0]               background,
  output logic                      frame_start
);

  // A zero hold time still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic             at_origin;
  logic             fs_evt;
  logic             origin_q;
  logic             frame_start_q;
  logic [SEL_W-1:0] active_sel_q;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;
  logic             win_hit;
  logic [1:0]       align;
  logic             bright_al;
  logic             hit_al;
  logic [11:0]      scr_pix;
  logic             scr_ok;
  logic [11:0]      rgb_d;
  logic [11:0]      rgb_q;
  bg_state_t        state_q;
  logic [11:0]      bg_q;
  logic [CNT_W-1:0] cnt_q;

  // Frame start fires on the first clock at (0,0), not on every dwell clock.
  assign at_origin = (hCount == 10'd0) && (vCount == 10'd0);
  assign fs_evt    = at_origin && !origin_q;

  // Track the previous origin flag and latch the screen select per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_q      <= 1'b0;
      frame_start_q <= 1'b0;
      active_sel_q  <= SEL_W'(SCR_BOARD);
    end else begin
      origin_q      <= at_origin;
      frame_start_q <= fs_evt;
      if (fs_evt) active_sel_q <= screen_sel;
    end
  end

  // Window test is done one bit wider so the exclusive far edge never overflows.
  assign h_ext   = {1'b0, hCount};
  assign v_ext   = {1'b0, vCount};
  assign win_hit = (h_ext >= 11'(WIN_X0)) && (h_ext < 11'(WIN_X0 + WIN_W)) &&
                   (v_ext >= 11'(WIN_Y0)) && (v_ext < 11'(WIN_Y0 + WIN_H));

  // Stage boundary: coordinates -> ROM-aligned flags (ROM_LATENCY clocks).
  simon_delay_line #(
    .W     (2),
    .DEPTH (ROM_LATENCY)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d_i ({bright, win_hit}),
    .q_o (align)
  );

  assign bright_al = align[1];
  assign hit_al    = align[0];

  // Select the active stream; indices beyond NUM_SCREENS never match.
  always_comb begin
    scr_pix = COL_BLACK;
    scr_ok  = 1'b0;
    for (int i = 0; i < NUM_SCREENS; i++) begin
      if (active_sel_q == SEL_W'(i)) begin
        scr_pix = screen_data[12*i +: 12];
        scr_ok  = SCREEN_EN[i];
      end
    end
    rgb_d = bg_q;
    if (!bright_al)           rgb_d = COL_BLACK;
    else if (hit_al && scr_ok) rgb_d = scr_pix;
  end

  // Stage boundary: aligned flags + ROM data -> registered pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rgb_q <= COL_BLACK;
    else     rgb_q <= rgb_d;
  end

  // Background FSM: buttons override everything, hold counts frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WHITE;
      bg_q    <= COL_WHITE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        WHITE: begin
          if (|btn) begin
            state_q <= PRESS;
            bg_q    <= btn_colour(btn);
          end else if (fs_evt) begin
            state_q <= IDLE;
            bg_q    <= COL_BLACK;
          end
        end
        IDLE: begin
          if (|btn) begin
            state_q <= PRESS;
            bg_q    <= btn_colour(btn);
          end
        end
        PRESS: begin
          if (|btn) begin
            bg_q <= btn_colour(btn);
          end else if (HOLD_FRAMES == 0) begin
            state_q <= IDLE;
            bg_q    <= COL_BLACK;
          end else begin
            state_q <= HOLD;
            cnt_q   <= CNT_W'(HOLD_FRAMES);
          end
        end
        HOLD: begin
          if (|btn) begin
            state_q <= PRESS;
            bg_q    <= btn_colour(btn);
          end else if (fs_evt) begin
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= IDLE;
              bg_q    <= COL_BLACK;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= WHITE;
          bg_q    <= COL_WHITE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rgb         = rgb_q;
  assign background  = bg_q;
  assign frame_start = frame_start_q;

endmodule
